prbs_checker8: RTL

PRBS_CHECKER8 -- requirements
Module: prbs_checker8

---
 rtl/prbs_checker8.sv | 137 +++++++++++++
 1 files changed

// File: rtl/prbs_checker8.sv
// PRBS checker for an 8-bit LFSR stream (taps 7,5,4,3).
// It fills an 8-bit history, searches for a run of consecutive matches, and
// then tracks the stream with its own free-running generator. While tracking,
// it counts bit errors. Too many errors in a 32-bit window drop it back to
// search.
module prbs_checker8 #(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        I,
    input  logic        VALID,
    input  logic        CLR,
    output logic        LOCKED,
    output logic        ERR,
    output logic [15:0] ERR_COUNT
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [5:0] UNLOCK_TH = 6'(UNLOCK_COUNT);

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  fill_q, fill_d;
    logic [7:0]  match_q, match_d;
    logic [4:0]  win_bits_q, win_bits_d;
    logic [5:0]  win_err_q, win_err_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        exp_bit;
    logic        mism;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next-state logic: history shift, match/window counters, and the error counter.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        fill_d     = fill_q;
        match_d    = match_q;
        win_bits_d = win_bits_q;
        win_err_d  = win_err_q;
        err_d      = 1'b0;
        cnt_d      = cnt_q;
        exp_bit    = sr_q[7] ^ sr_q[5] ^ sr_q[4] ^ sr_q[3];
        mism       = I ^ exp_bit;

        if (VALID) begin
            case (state_q)
                ST_FILL: begin
                    sr_d   = {sr_q[6:0], I};
                    fill_d = fill_q + 3'd1;
                    if (fill_q == 3'd7) begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    sr_d = {sr_q[6:0], I};
                    // An all-zero history predicting a zero is not evidence of a live stream.
                    if (!mism && !((sr_q == 8'h00) && !I)) begin
                        if (match_q == LOCK_LAST) begin
                            state_d    = ST_LOCKED;
                            match_d    = 8'd0;
                            win_bits_d = 5'd0;
                            win_err_d  = 6'd0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    // Feed back the prediction, so one corrupted input bit costs exactly one error.
                    sr_d       = {sr_q[6:0], exp_bit};
                    win_bits_d = win_bits_q + 5'd1;
                    if (mism) begin
                        err_d     = 1'b1;
                        cnt_d     = sat_inc16(cnt_q);
                        win_err_d = win_err_q + 6'd1;
                    end
                    if (win_bits_q == 5'd31) begin
                        if (win_err_d >= UNLOCK_TH) begin
                            state_d = ST_SEARCH;
                            match_d = 8'd0;
                        end
                        win_err_d = 6'd0;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end

        if (CLR) begin
            cnt_d = 16'd0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_FILL;
            sr_q       <= 8'h00;
            fill_q     <= 3'd0;
            match_q    <= 8'd0;
            win_bits_q <= 5'd0;
            win_err_q  <= 6'd0;
            err_q      <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            win_bits_q <= win_bits_d;
            win_err_q  <= win_err_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign LOCKED    = (state_q == ST_LOCKED);
    assign ERR       = err_q;
    assign ERR_COUNT = cnt_q;

endmodule
